// File: rtl/corr_shift_if.sv
// Bundle between the correlation accumulator, the shift controller and its host:
// frame strobe plus diagonal terms in, chosen shift and frame gating out.
interface corr_shift_if #(
  parameter int CORR_DOUT_WIDTH = 32
);
  logic                              auto_en;
  logic [4:0]                        manual_shift;
  logic                              corr_valid;
  logic signed [CORR_DOUT_WIDTH-1:0] r11;
  logic signed [CORR_DOUT_WIDTH-1:0] r22;
  logic [4:0]                        shift;
  logic                              frame_ok;
  logic                              ovf;
  logic [1:0]                        state_dbg;

  modport master (
    output auto_en, manual_shift, corr_valid, r11, r22,
    input  shift, frame_ok, ovf, state_dbg
  );

  modport slave (
    input  auto_en, manual_shift, corr_valid, r11, r22,
    output shift, frame_ok, ovf, state_dbg
  );
endinterface

// File: rtl/corr_shift_ctrl.sv
// Per-frame automatic scaling of the correlation-to-eigen narrowing cast, with
// settle gating after every shift change and a manual bypass.
module corr_shift_ctrl #(
  parameter int CORR_DOUT_WIDTH = 32,
  parameter int CORR_POINT      = 16,
  parameter int MAX_SHIFT       = 31,
  parameter int INIT_SHIFT      = 0,
  parameter int UDF_MARGIN      = 2,
  parameter int UDF_FRAMES      = 4,
  parameter int SETTLE_FRAMES   = 2
) (
  input logic         clk,
  input logic         rst_n,
  corr_shift_if.slave bus
);
  localparam int W = CORR_DOUT_WIDTH;

  localparam logic [1:0] ST_TRACK  = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_MANUAL = 2'd2;

  localparam logic [4:0]   MAX_S         = 5'(MAX_SHIFT);
  localparam logic [4:0]   INIT_S        = 5'(INIT_SHIFT);
  localparam logic [7:0]   SETTLE_RELOAD = 8'(SETTLE_FRAMES);
  localparam logic [7:0]   UDF_LIMIT     = 8'(UDF_FRAMES);
  localparam logic [W-1:0] OVF_LIM       = W'(1) << (CORR_POINT + 1);
  localparam logic [W-1:0] UDF_LIM       = W'(1) << (CORR_POINT + 1 - UDF_MARGIN);

  logic [1:0] state_q, state_d;
  logic [4:0] shift_q, shift_d;
  logic [7:0] udf_cnt_q, udf_cnt_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic       ovf_q, ovf_d;
  logic       frame_ok_q, frame_ok_d;

  logic signed [W-1:0] r11_s, r22_s, peak;
  logic [W-1:0]        peak_sh;
  logic                is_ovf, is_udf;

  assign r11_s = bus.r11;
  assign r22_s = bus.r22;
  assign peak  = (r11_s > r22_s) ? r11_s : r22_s;

  // Comparing peak>>s against fixed limits keeps every threshold inside W bits;
  // once CORR_POINT+1+s reaches W-1 the shifted peak can never hit OVF_LIM.
  assign peak_sh = $unsigned(peak) >> shift_q;
  assign is_ovf  = r11_s[W-1] | r22_s[W-1] | (peak_sh >= OVF_LIM);
  assign is_udf  = !is_ovf && (peak_sh < UDF_LIM);

  logic [1:0] mode;
  logic [7:0] udf_base;
  logic [7:0] udf_inc;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    udf_cnt_d    = udf_cnt_q;
    settle_cnt_d = settle_cnt_q;
    ovf_d        = ovf_q;
    frame_ok_d   = 1'b0;
    mode         = state_q;
    udf_base     = udf_cnt_q;
    udf_inc      = 8'd0;

    if (!bus.auto_en) begin
      state_d      = ST_MANUAL;
      shift_d      = bus.manual_shift;
      udf_cnt_d    = 8'd0;
      settle_cnt_d = 8'd0;
      if (bus.corr_valid) begin
        frame_ok_d = 1'b1;
        if (is_ovf) ovf_d = 1'b1;
      end
    end else begin
      // Returning to auto: shift is kept (bumpless), history is dropped.
      if (state_q == ST_MANUAL) begin
        mode         = ST_TRACK;
        state_d      = ST_TRACK;
        udf_base     = 8'd0;
        udf_cnt_d    = 8'd0;
        settle_cnt_d = 8'd0;
        ovf_d        = 1'b0;
      end

      if (bus.corr_valid && mode == ST_TRACK) begin
        if (is_ovf) begin
          ovf_d     = 1'b1;
          udf_cnt_d = 8'd0;
          if (shift_q < MAX_S) begin
            shift_d      = shift_q + 5'd1;
            settle_cnt_d = SETTLE_RELOAD;
            state_d      = ST_SETTLE;
          end
        end else begin
          frame_ok_d = 1'b1;
          if (is_udf) begin
            udf_inc = (udf_base >= UDF_LIMIT) ? UDF_LIMIT : udf_base + 8'd1;
            if (udf_inc >= UDF_LIMIT && shift_q != 5'd0) begin
              shift_d      = shift_q - 5'd1;
              udf_cnt_d    = 8'd0;
              settle_cnt_d = SETTLE_RELOAD;
              state_d      = ST_SETTLE;
            end else begin
              udf_cnt_d = udf_inc;
            end
          end else begin
            udf_cnt_d = 8'd0;
          end
        end
      end else if (bus.corr_valid && mode == ST_SETTLE) begin
        if (is_ovf) begin
          ovf_d        = 1'b1;
          settle_cnt_d = SETTLE_RELOAD;
          if (shift_q < MAX_S) shift_d = shift_q + 5'd1;
        end else if (settle_cnt_q <= 8'd1) begin
          settle_cnt_d = 8'd0;
          state_d      = ST_TRACK;
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_TRACK;
      shift_q      <= INIT_S;
      udf_cnt_q    <= 8'd0;
      settle_cnt_q <= 8'd0;
      ovf_q        <= 1'b0;
      frame_ok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      udf_cnt_q    <= udf_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      ovf_q        <= ovf_d;
      frame_ok_q   <= frame_ok_d;
    end
  end

  assign bus.shift     = shift_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.ovf       = ovf_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_corr_shift_ctrl.sv
// Directed plus randomized checking of corr_shift_ctrl against a frame-level
// reference model evaluated with plain integer arithmetic.
module tb_corr_shift_ctrl;
  localparam int CP     = 16;
  localparam int MARGIN = 2;
  localparam int MAXS   = 31;
  localparam int UDF    = 4;
  localparam int SETTLE = 2;
  localparam int M_TRK  = 0;
  localparam int M_SET  = 1;
  localparam int M_MAN  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  corr_shift_if #(.CORR_DOUT_WIDTH(32)) bus ();

  corr_shift_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int m_mode, m_shift, m_udf, m_settle;
  bit m_ovf, m_fok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_TRK; m_shift = 0; m_udf = 0; m_settle = 0; m_ovf = 0; m_fok = 0;
  endtask

  task automatic check_all();
    chk("shift", 32'(bus.shift), 32'(m_shift));
    chk("frame_ok", 32'(bus.frame_ok), 32'(m_fok));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("state", 32'(bus.state_dbg), 32'(m_mode));
  endtask

  // Caller is positioned at a negedge; inputs are applied for one clock.
  task automatic step(input bit ae, input int ms, input bit v, input int a, input int b);
    longint pa, pb, peak;
    bit o, u;
    bus.auto_en = ae; bus.manual_shift = 5'(ms); bus.corr_valid = v;
    bus.r11 = a; bus.r22 = b;
    pa = a; pb = b;
    peak = (pa > pb) ? pa : pb;
    o = (pa < 0) || (pb < 0) || (peak >= (longint'(1) << (CP + 1 + m_shift)));
    u = !o && (peak < (longint'(1) << (CP + 1 - MARGIN + m_shift)));
    m_fok = 0;
    if (!ae) begin
      if (v) begin m_fok = 1; if (o) m_ovf = 1; end
      m_mode = M_MAN; m_shift = ms; m_udf = 0; m_settle = 0;
    end else begin
      if (m_mode == M_MAN) begin m_mode = M_TRK; m_udf = 0; m_settle = 0; m_ovf = 0; end
      if (v && m_mode == M_TRK) begin
        if (o) begin
          m_ovf = 1; m_udf = 0;
          if (m_shift < MAXS) begin m_shift++; m_settle = SETTLE; m_mode = M_SET; end
        end else begin
          m_fok = 1;
          if (u) begin
            m_udf = (m_udf + 1 > UDF) ? UDF : m_udf + 1;
            if (m_udf == UDF && m_shift > 0) begin
              m_shift--; m_udf = 0; m_settle = SETTLE; m_mode = M_SET;
            end
          end else m_udf = 0;
        end
      end else if (v && m_mode == M_SET) begin
        if (o) begin
          m_ovf = 1; m_settle = SETTLE;
          if (m_shift < MAXS) m_shift++;
        end else begin
          m_settle--;
          if (m_settle <= 0) begin m_settle = 0; m_mode = M_TRK; end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    @(negedge clk);
  endtask

  task automatic frame(input bit ae, input int ms, input int a, input int b);
    step(ae, ms, 1'b1, a, b);
    step(ae, ms, 1'b0, 0, 0);
  endtask

  function automatic int rnd_val();
    int bits;
    logic [31:0] mask;
    if ($urandom_range(0, 7) == 0) return -int'($urandom_range(1, 100000));
    bits = $urandom_range(8, 31);
    mask = (32'h1 << bits) - 32'h1;
    return int'($urandom & mask);
  endfunction

  initial begin
    bit ae, v, last_v;
    int ms;
    bus.auto_en = 1'b1; bus.manual_shift = 5'd0; bus.corr_valid = 1'b0;
    bus.r11 = 0; bus.r22 = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) frame(1, 0, 1 << 16, 1 << 16);
    repeat (7) frame(1, 0, 1 << 20, 0);
    repeat (6) frame(1, 0, 1 << 16, 1 << 16);
    repeat (6) frame(1, 0, 1 << 16, 1 << 16);
    repeat (3) frame(1, 0, 1 << 16, -1);
    step(0, 3, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    step(0, 7, 0, 0, 0);
    repeat (2) frame(0, 7, 1 << 16, 1 << 16);
    frame(0, 7, 1 << 30, 0);
    step(1, 7, 0, 0, 0);
    frame(1, 7, 1 << 30, 0);

    // Asynchronous reset in the middle of a settle window.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) frame(1, 0, 1 << 16, 1 << 16);

    ae = 1'b1; ms = 0; last_v = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) ae = !ae;
      if ($urandom_range(0, 3) == 0) ms = $urandom_range(0, 31);
      v = !last_v && ($urandom_range(0, 1) == 1);
      step(ae, ms, v, rnd_val(), rnd_val());
      last_v = v;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/corr_shift_ctrl.md
Name: corr_shift_ctrl

Overview:
- Automatic scaling controller for the correlation-to-eigen path of the UESPRIT linear-algebra chain.
- Once per accumulated frame, inspects the diagonal correlation terms r11 and r22 and chooses the arithmetic right-shift applied before the narrowing cast into the eigen solver.
- Withholds frames from the eigen stage while a new shift settles.
- Includes a manual bypass for debugging.

Parameters:
- CORR_DOUT_WIDTH, 32, width of the correlation outputs r11/r22.
- CORR_POINT, 16, fractional bits of the correlation outputs; eigen input window top bit is CORR_POINT+1.
- MAX_SHIFT, 31, upper saturation of shift (must be ≤31).
- INIT_SHIFT, 0, shift value after reset.
- UDF_MARGIN, 2, headroom bits defining underflow.
- UDF_FRAMES, 4, consecutive underflow frames before shift is decremented.
- SETTLE_FRAMES, 2, frames discarded after any shift change.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- auto_en  in  1  1 = automatic control, 0 = manual.
- manual_shift  in  5  shift used when auto_en=0.
- corr_valid  in  1  one-cycle pulse, r11/r22 valid.
- r11  in  CORR_DOUT_WIDTH  signed diagonal term.
- r22  in  CORR_DOUT_WIDTH  signed diagonal term.
- shift  out  5  shift to the datapath (registered).
- frame_ok  out  1  one-cycle pulse; the frame just received may be consumed by the eigen stage.
- ovf  out  1  sticky overflow seen since last auto_en rise or reset.
- state_dbg  out  2  current state encoding.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=MANUAL if auto_en=0, else TRACK (sampled after release; reset forces TRACK).
  - shift=INIT_SHIFT.
  - frame_ok=0, ovf=0.
  - udf_cnt=0, settle_cnt=0.
- States: TRACK=0, SETTLE=1, MANUAL=2.
- Per-frame evaluation on corr_valid, using current shift s; decisions are registered and visible on the following cycle (latency 1):
  - peak = max(r11, r22), signed compare.
  - OVF = (r11<0) | (r22<0) | (peak ≥ 2^(CORR_POINT+1+s)). Negative diagonals indicate wrap and count as overflow.
  - UDF = !OVF & (peak < 2^(CORR_POINT+1-UDF_MARGIN+s)).
  - Thresholds use compare against shifted constants or peak>>>s. Width-safe: when CORR_POINT+1+s ≥ CORR_DOUT_WIDTH-1, OVF by magnitude is impossible.
- TRACK on corr_valid:
  - OVF: shift=min(s+1, MAX_SHIFT), ovf=1, udf_cnt=0, settle_cnt=SETTLE_FRAMES, next state SETTLE, frame_ok=0.
  - UDF: udf_cnt+1; if it reaches UDF_FRAMES and s>0, then shift=s-1, udf_cnt=0, go to SETTLE. In both cases frame_ok=1 for this frame, since it is still in range.
  - Otherwise: udf_cnt=0, frame_ok=1.
- OVF at s=MAX_SHIFT: shift holds, ovf=1, stay TRACK, frame_ok=0.
- UDF at s=0: counter saturates at UDF_FRAMES, no change, frame_ok=1.
- SETTLE on corr_valid:
  - frame_ok=0, settle_cnt-1.
  - OVF in SETTLE: shift increments again (saturated) and settle_cnt reloads.
  - When settle_cnt reaches 0, return to TRACK. SETTLE_FRAMES=0 means return on the same frame.
- MANUAL:
  - shift=manual_shift every cycle (1-cycle lag).
  - frame_ok=corr_valid delayed 1.
  - OVF still updates ovf. No auto adjustment.
- auto_en fall (any state): next cycle MANUAL. An in-progress SETTLE is aborted.
- auto_en rise: next cycle TRACK with shift held (bumpless), counters and ovf cleared.
- corr_valid coincident with an auto_en edge: the mode transition wins and the frame is evaluated under the new mode's rules.
- frame_ok is never high for two consecutive cycles; corr_valid is guaranteed spaced ≥2 cycles apart.
- Datapath contract: shift changes only on the cycle after a corr_valid. The datapath samples shift on the next corr_valid, so each frame is scaled by a single constant shift.

Test Plan:
- Reset, auto_en=1, INIT_SHIFT=0, frames with r11=r22=2^16 → shift stays 0, frame_ok pulses 1 cycle after each corr_valid, ovf=0.
- r11=2^20 with s=0 → shift 1 one cycle later, SETTLE; next 2 frames get frame_ok=0. Repeated overflow steps shift until 2^20 < 2^(17+s), i.e. final shift=4. Then TRACK with frame_ok resuming.
- Shift=4, frames with peak=2^16 (< 2^19): frames 1–3 give frame_ok=1 and no change; frame 4 gives shift=3 and SETTLE.
- r22=-1 with s=2 → OVF, shift=3, ovf sticky=1. auto_en toggle 0→1 clears ovf and keeps shift=3.
- auto_en=0, manual_shift=7 → shift=7 next cycle, frame_ok follows corr_valid. Huge r11 → ovf=1 but shift stays 7.
- Assert rst_n low mid-SETTLE → shift=INIT_SHIFT immediately (async), frame_ok=0, resumes TRACK after release.
